fg_sram_arbiter: RTL

- Owns the single-port foreground SRAM and shares it between three requesters: pipeline foreground pixel reads, SPI image uploads, and live capture writes.
- Pipeline reads have absolute priority and return after a fixed latency of exactly FOREGROUND_FETCH_CYCLE_DELAY cycles.
- Writes are buffered in per-source FIFOs and drain into cycles with no read.
- Sits between controlled_pipeline (fg request/return, ctrl_image_* and ctrl_fg_freeze) and the SRAM pins.

---
 rtl/fg_sram_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM arbiter: fixed-latency pipeline reads with absolute priority,
// SPI and capture writes buffered in small FIFOs and drained round-robin into idle slots.

module fg_wfifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module fg_sram_arbiter #(
    parameter int PRECISION                    = 11,
    parameter int PIXEL_SIZE                   = 16,
    parameter int RESOLUTION_X                 = 800,
    parameter int RESOLUTION_Y                 = 600,
    parameter int ADDR_WIDTH                   = 19,
    parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5,
    parameter int SRAM_READ_LATENCY            = 2,
    parameter int FIFO_DEPTH                   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRECISION:0]    fg_pixel_request_x,
    input  logic [PRECISION:0]    fg_pixel_request_y,
    input  logic                  fg_pixel_request_active,
    output logic [PIXEL_SIZE-1:0] fg_pixel_in,
    output logic                  fg_pixel_ready,
    input  logic [PRECISION-1:0]  ctrl_image_pixel_x,
    input  logic [PRECISION-1:0]  ctrl_image_pixel_y,
    input  logic [PIXEL_SIZE-1:0] ctrl_image_pixel,
    input  logic                  ctrl_image_pixel_ready,
    input  logic [PRECISION-1:0]  cap_pixel_x,
    input  logic [PRECISION-1:0]  cap_pixel_y,
    input  logic [PIXEL_SIZE-1:0] cap_pixel,
    input  logic                  cap_pixel_ready,
    input  logic                  ctrl_fg_freeze,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [PIXEL_SIZE-1:0] sram_wdata,
    output logic                  sram_we,
    output logic                  sram_re,
    input  logic [PIXEL_SIZE-1:0] sram_rdata,
    output logic                  spi_overflow,
    output logic                  cap_overflow
);
    localparam int ENTRY_W     = ADDR_WIDTH + PIXEL_SIZE;
    localparam int FETCH       = FOREGROUND_FETCH_CYCLE_DELAY;
    localparam int DATA_STAGES = FETCH - 1 - SRAM_READ_LATENCY;

    function automatic logic coord_ok(input logic [PRECISION-1:0] x,
                                      input logic [PRECISION-1:0] y);
        return (32'(x) < 32'(RESOLUTION_X)) && (32'(y) < 32'(RESOLUTION_Y));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [PRECISION-1:0] x,
                                                       input logic [PRECISION-1:0] y);
        logic [31:0] lin;
        lin = 32'(y) * 32'(RESOLUTION_X) + 32'(x);
        return lin[ADDR_WIDTH-1:0];
    endfunction

    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  spi_wr_ok;
    logic                  cap_wr_ok;
    logic                  spi_push;
    logic                  cap_push;
    logic                  spi_pop;
    logic                  cap_pop;
    logic                  spi_empty;
    logic                  spi_full;
    logic                  cap_empty;
    logic                  cap_full;
    logic [ENTRY_W-1:0]    spi_entry;
    logic [ENTRY_W-1:0]    cap_entry;
    logic [ENTRY_W-1:0]    spi_head;
    logic [ENTRY_W-1:0]    cap_head;
    logic                  wr_go;
    logic                  sel_cap;
    logic                  rr_cap;
    logic [FETCH-1:0]      rd_vld;
    logic [PIXEL_SIZE-1:0] pix_pipe [DATA_STAGES];

    // negative coordinates show up as a set sign bit
    always_comb begin
        rd_ok = fg_pixel_request_active
             && !fg_pixel_request_x[PRECISION] && !fg_pixel_request_y[PRECISION]
             && coord_ok(fg_pixel_request_x[PRECISION-1:0], fg_pixel_request_y[PRECISION-1:0]);
        rd_addr   = pix_addr(fg_pixel_request_x[PRECISION-1:0], fg_pixel_request_y[PRECISION-1:0]);
        spi_entry = {pix_addr(ctrl_image_pixel_x, ctrl_image_pixel_y), ctrl_image_pixel};
        cap_entry = {pix_addr(cap_pixel_x, cap_pixel_y), cap_pixel};
        spi_wr_ok = ctrl_image_pixel_ready && coord_ok(ctrl_image_pixel_x, ctrl_image_pixel_y);
        cap_wr_ok = cap_pixel_ready && !ctrl_fg_freeze && coord_ok(cap_pixel_x, cap_pixel_y);
    end

    // a pop in the same cycle frees the slot a full FIFO needs for its push
    always_comb begin
        wr_go    = !rd_ok && !(spi_empty && cap_empty);
        sel_cap  = !cap_empty && (spi_empty || rr_cap);
        spi_pop  = wr_go && !sel_cap;
        cap_pop  = wr_go && sel_cap;
        spi_push = spi_wr_ok && (!spi_full || spi_pop);
        cap_push = cap_wr_ok && (!cap_full || cap_pop);
    end

    fg_wfifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_spi_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (spi_push),
        .wdata (spi_entry),
        .pop   (spi_pop),
        .rdata (spi_head),
        .empty (spi_empty),
        .full  (spi_full)
    );

    fg_wfifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_cap_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_push),
        .wdata (cap_entry),
        .pop   (cap_pop),
        .rdata (cap_head),
        .empty (cap_empty),
        .full  (cap_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_we      <= 1'b0;
            sram_re      <= 1'b0;
            rr_cap       <= 1'b0;
            spi_overflow <= 1'b0;
            cap_overflow <= 1'b0;
        end else begin
            if (rd_ok) begin
                sram_re   <= 1'b1;
                sram_we   <= 1'b0;
                sram_addr <= rd_addr;
            end else if (wr_go) begin
                sram_re                 <= 1'b0;
                sram_we                 <= 1'b1;
                {sram_addr, sram_wdata} <= sel_cap ? cap_head : spi_head;
                rr_cap                  <= !sel_cap;
            end else begin
                sram_re <= 1'b0;
                sram_we <= 1'b0;
            end
            if (spi_wr_ok && spi_full && !spi_pop) spi_overflow <= 1'b1;
            if (cap_wr_ok && cap_full && !cap_pop) cap_overflow <= 1'b1;
        end
    end

    // rd_vld[k] marks a read issued k cycles ago; data stages load only behind a valid read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
            for (int k = 0; k < DATA_STAGES; k++) pix_pipe[k] <= '0;
        end else begin
            rd_vld <= {rd_vld[FETCH-2:0], rd_ok};
            if (rd_vld[SRAM_READ_LATENCY]) pix_pipe[0] <= sram_rdata;
            for (int k = 1; k < DATA_STAGES; k++) begin
                if (rd_vld[SRAM_READ_LATENCY+k]) pix_pipe[k] <= pix_pipe[k-1];
            end
        end
    end

    assign fg_pixel_ready = rd_vld[FETCH-1];
    assign fg_pixel_in    = pix_pipe[DATA_STAGES-1];
endmodule
